gcd_stein: RTL and testbench

Parametrised successor to the 32-bit subtractive gcd unit, computing the greatest common divisor with the binary (Stein) algorithm.
- Reduction is shift/subtract only, so worst-case latency is bounded by WIDTH rather than by operand magnitude.
- Adds zero-operand handling, an error flag, a busy indicator and level-held done/result.
- Sits behind the same start/done handshake used by the existing gcd benches, so bench stimulus loops carry over unchanged.

---
 rtl/gcd_stein.sv | 123 ++++++++++++
 tb/tb_gcd_stein.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gcd_stein.sv
// Binary (Stein) GCD unit with start/done handshake, zero-operand handling and error flag.
// Optional cycle counter on the cycles port is enabled by defining GCD_CYCLE_CNT_EN.
module gcd_stein #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic [CNT_W-1:0] cycles
);

    localparam int K_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StCheck, StStrip, StReduce} state_e;

    state_e         state_q;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [K_W-1:0] k_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            k_q     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            err     <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        x_q     <= a_in;
                        y_q     <= b_in;
                        k_q     <= '0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        err     <= 1'b0;
                        state_q <= StCheck;
                    end
                end
                StCheck: begin
                    if (x_q == '0 || y_q == '0) begin
                        result  <= x_q | y_q;
                        err     <= (x_q == '0) && (y_q == '0);
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        state_q <= StStrip;
                    end
                end
                StStrip: begin
                    // Remove the common power of two; k remembers how much to restore.
                    if (!x_q[0] && !y_q[0]) begin
                        x_q <= x_q >> 1;
                        y_q <= y_q >> 1;
                        k_q <= k_q + 1'b1;
                    end else begin
                        state_q <= StReduce;
                    end
                end
                StReduce: begin
                    if (!x_q[0]) begin
                        x_q <= x_q >> 1;
                    end else if (!y_q[0]) begin
                        y_q <= y_q >> 1;
                    end else if (x_q == y_q) begin
                        result  <= x_q << k_q;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end else if (x_q > y_q) begin
                        x_q <= (x_q - y_q) >> 1;
                    end else begin
                        y_q <= (y_q - x_q) >> 1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef GCD_CYCLE_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             finish;

    always_comb begin
        cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
        finish  = ((state_q == StCheck) && (x_q == '0 || y_q == '0)) ||
                  ((state_q == StReduce) && x_q[0] && y_q[0] && (x_q == y_q));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            cycles <= '0;
        end else if (state_q == StIdle) begin
            // The acceptance cycle itself is counted as the first cycle.
            if (start) cnt_q <= {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (busy) begin
            cnt_q <= cnt_inc;
            if (finish) cycles <= cnt_inc;
        end
    end
`else
    assign cycles = '0;
`endif

endmodule

// File: tb/tb_gcd_stein.sv
// Directed bench for gcd_stein: 32-bit and 8-bit instances, handshake, zero operands, reset.
module tb_gcd_stein;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32, err32;
    logic [31:0] res32;
    logic [7:0]  cyc32;
    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, err8;
    logic [7:0]  res8;
    logic [7:0]  cyc8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gcd_stein #(.WIDTH(32), .CNT_W(8)) dut32 (
        .clk(clk), .reset_n(reset_n), .start(start32), .a_in(a32), .b_in(b32),
        .busy(busy32), .done(done32), .result(res32), .err(err32), .cycles(cyc32)
    );

    gcd_stein #(.WIDTH(8), .CNT_W(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .a_in(a8), .b_in(b8),
        .busy(busy8), .done(done8), .result(res8), .err(err8), .cycles(cyc8)
    );

    function automatic int unsigned euclid(input int unsigned a, input int unsigned b);
        int unsigned t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // lat counts rising edges from the acceptance edge through the done edge, both inclusive.
    task automatic op32(input logic [31:0] a, input logic [31:0] b, output int lat);
        @(negedge clk);
        a32 = a; b32 = b; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        lat = 1;
        while (!done32 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, output int lat);
        @(negedge clk);
        a8 = a; b8 = b; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = 1;
        while (!done8 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        #12;
        checks++;
        if ({busy32, done32, err32, res32, cyc32} !== 43'd0) begin
            errors++;
            $display("FAIL reset32 got busy=%b done=%b err=%b res=%h cyc=%0d want all 0",
                     busy32, done32, err32, res32, cyc32);
        end
        checks++;
        if ({busy8, done8, err8, res8, cyc8} !== 19'd0) begin
            errors++;
            $display("FAIL reset8 got busy=%b done=%b err=%b res=%h want all 0",
                     busy8, done8, err8, res8);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_basic;
        int lat;
        op32(32'd48, 32'd18, lat);
        checks++;
        if (res32 !== 32'd6 || err32 !== 1'b0 || busy32 !== 1'b0 || done32 !== 1'b1 || lat > 67) begin
            errors++;
            $display("FAIL gcd_48_18 got res=%0d err=%b busy=%b done=%b lat=%0d want 6 0 0 1 <=67",
                     res32, err32, busy32, done32, lat);
        end
    endtask

    task automatic test_zero;
        logic [31:0] av [3] = '{32'd0, 32'd7, 32'd0};
        logic [31:0] bv [3] = '{32'd7, 32'd0, 32'd0};
        logic [31:0] rv [3] = '{32'd7, 32'd7, 32'd0};
        logic        ev [3] = '{1'b0, 1'b0, 1'b1};
        int lat;
        for (int i = 0; i < 3; i++) begin
            op32(av[i], bv[i], lat);
            checks++;
            if (res32 !== rv[i] || err32 !== ev[i] || done32 !== 1'b1 || lat != 2) begin
                errors++;
                $display("FAIL zero_op%0d got res=%0d err=%b done=%b lat=%0d want %0d %b 1 2",
                         i, res32, err32, done32, lat, rv[i], ev[i]);
            end
        end
    endtask

    task automatic test_pow2;
        int lat;
        op32(32'h8000_0000, 32'h4000_0000, lat);
        checks++;
        if (res32 !== 32'h4000_0000 || err32 !== 1'b0 || lat > 67) begin
            errors++;
            $display("FAIL pow2 got res=%h err=%b lat=%0d want 40000000 0 <=67", res32, err32, lat);
        end
        op32(32'd13, 32'd13, lat);
        checks++;
        if (res32 !== 32'd13 || err32 !== 1'b0) begin
            errors++;
            $display("FAIL equal13 got res=%0d err=%b want 13 0", res32, err32);
        end
    endtask

    task automatic test_width8;
        int lat;
        logic [7:0] a, b;
        op8(8'd255, 8'd170, lat);
        checks++;
        if (res8 !== 8'd85 || err8 !== 1'b0 || lat > 19) begin
            errors++;
            $display("FAIL w8_255_170 got res=%0d err=%b lat=%0d want 85 0 <=19", res8, err8, lat);
        end
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            op8(a, b, lat);
            checks++;
            if (res8 !== 8'(euclid(a, b)) || err8 !== (a == 0 && b == 0) || lat > 19) begin
                errors++;
                $display("FAIL w8_rand a=%0d b=%0d got res=%0d err=%b lat=%0d want %0d",
                         a, b, res8, err8, lat, euclid(a, b));
            end
        end
    endtask

    task automatic test_ignore_start;
        int lat;
        @(negedge clk);
        a32 = 32'h8000_0000; b32 = 32'h4000_0000; start32 = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1 || c == 3 || c == 5) begin
                a32 = 32'd15 * c; b32 = 32'd5 * c; start32 = 1'b1;
            end else begin
                start32 = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start32 = 1'b0;
        while (!done32 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (res32 !== 32'h4000_0000 || done32 !== 1'b1) begin
            errors++;
            $display("FAIL ignore_start got res=%h done=%b want 40000000 1", res32, done32);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (done32 !== 1'b1 || busy32 !== 1'b0 || res32 !== 32'h4000_0000) begin
            errors++;
            $display("FAIL no_second_result got done=%b busy=%b res=%h want 1 0 40000000",
                     done32, busy32, res32);
        end
        // Abort mid-operation with an asynchronous reset between clock edges.
        @(negedge clk);
        a32 = 32'd48; b32 = 32'd18; start32 = 1'b1;
        @(posedge clk); #1;
        start32 = 1'b0;
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy32 !== 1'b0 || done32 !== 1'b0 || res32 !== 32'd0) begin
            errors++;
            $display("FAIL async_reset got busy=%b done=%b res=%h want 0 0 0", busy32, done32, res32);
        end
        @(negedge clk);
        reset_n = 1'b1;
        op32(32'd100, 32'd75, lat);
        checks++;
        if (res32 !== 32'd25 || err32 !== 1'b0 || done32 !== 1'b1) begin
            errors++;
            $display("FAIL after_reset got res=%0d err=%b done=%b want 25 0 1", res32, err32, done32);
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        @(negedge clk);
        a32 = 32'd12; b32 = 32'd18; start32 = 1'b1;
        @(posedge clk); #1;
        lat = 1;
        while (!done32 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (res32 !== 32'd6 || done32 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_first got res=%0d done=%b want 6 1", res32, done32);
        end
        a32 = 32'd35; b32 = 32'd21;
        @(posedge clk); #1;
        start32 = 1'b0;
        checks++;
        if (done32 !== 1'b0 || busy32 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept got done=%b busy=%b want 0 1", done32, busy32);
        end
        lat = 1;
        while (!done32 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (res32 !== 32'd7 || done32 !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second got res=%0d done=%b want 7 1", res32, done32);
        end
    endtask

    task automatic test_cycles;
        int lat;
        op32(32'd48, 32'd18, lat);
`ifdef GCD_CYCLE_CNT_EN
        checks++;
        if (cyc32 !== 8'd9 || lat != 9) begin
            errors++;
            $display("FAIL cycles got cyc=%0d lat=%0d want 9 9", cyc32, lat);
        end
`else
        checks++;
        if (cyc32 !== 8'd0 || cyc8 !== 8'd0) begin
            errors++;
            $display("FAIL cycles_off got cyc32=%0d cyc8=%0d want 0 0", cyc32, cyc8);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_pow2();
        test_width8();
        test_ignore_start();
        test_back_to_back();
        test_cycles();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
